// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, start-bit qualification at
// mid-bit, mid-bit data/stop sampling, one-cycle done / framing-error strobes.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a high here means the edge was a glitch.
        if (cnt_q == HALF_LAST) begin
          if (!rx_s_q) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit lets an immediately following start edge be caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data      = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q == S_DATA) || (state_q == S_STOP) || (state_q == S_BREAK);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: behavioural 8N1 transmitter, scoreboard of
// expected bytes popped on each rx_done, per-scenario tasks.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 250_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int          LAT_NOM  = 2 + int'(CPB / 2) + 9 * int'(CPB);

  logic       clk_50M = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int done_cnt      = 0;
  int ferr_cnt      = 0;
  int last_done_cyc = 0;
  int start_cyc     = 0;
  bit busy_seen     = 1'b0;
  bit prev_strobe   = 1'b0;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk_50M   (clk_50M),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc++;

  // Scoreboard: every rx_done pops the oldest expected byte.
  always @(negedge clk_50M) begin
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (rx_done && frame_err) begin
        checks++; errors++;
        $display("FAIL strobe_excl: rx_done=%b frame_err=%b, required not both high", rx_done, frame_err);
      end
      if ((rx_done || frame_err) && prev_strobe) begin
        checks++; errors++;
        $display("FAIL strobe_consec: strobe on consecutive cycles at cycle %0d", cyc);
      end
      prev_strobe = rx_done || frame_err;
      if (frame_err) ferr_cnt++;
      if (rx_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: data=%02h with empty scoreboard", data);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          if (data !== e) begin
            errors++;
            $display("FAIL scoreboard_data: got %02h, expected %02h", data, e);
          end
        end
      end
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                            input int period, input bit expect_ok);
    if (expect_ok) exp_q.push_back(b);
    @(posedge clk_50M); #1;
    rx = 1'b0;
    start_cyc = cyc;
    wait_cycles(period);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(period);
    end
    rx = stop_lvl;
    wait_cycles(period);
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d bytes not received, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(3);
    checks++; if (data !== 8'h00)   begin errors++; $display("FAIL reset_data: got %02h, expected 00", data); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b, expected 0", rx_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_loopback;
    int d0, f0, lat;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, CPB, 1'b1);
    wait_cycles(CPB);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL loop_done_count: got %0d, expected 1", done_cnt - d0); end
    lat = last_done_cyc - start_cyc;
    checks++; if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin
      errors++; $display("FAIL loop_latency: got %0d cycles, expected %0d +/-2", lat, LAT_NOM);
    end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL loop_data: got %02h, expected a5", data); end
    checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL loop_ferr: got %0d pulses, expected 0", ferr_cnt - f0); end
    check_queue_empty("loop");
  endtask

  task automatic test_boundary;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b1, CPB, 1'b1);
    wait_cycles(CPB);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL bound_data00: got %02h, expected 00", data); end
    send_frame(8'hFF, 1'b1, CPB, 1'b1);
    wait_cycles(CPB);
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL bound_dataff: got %02h, expected ff", data); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL bound_done_count: got %0d, expected 2", done_cnt - d0); end
    checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL bound_ferr: got %0d pulses, expected 0", ferr_cnt - f0); end
    check_queue_empty("bound");
  endtask

  task automatic test_glitch;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    wait_cycles(CPB / 4);
    rx = 1'b1;
    wait_cycles(2 * CPB);
    checks++; if (busy_seen) begin errors++; $display("FAIL glitch_busy: busy seen high, expected never"); end
    checks++; if (done_cnt != d0 || ferr_cnt != f0) begin
      errors++; $display("FAIL glitch_strobe: done=%0d ferr=%0d, expected 0 0", done_cnt - d0, ferr_cnt - f0);
    end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL glitch_data_hold: got %02h, expected ff", data); end
    send_frame(8'h3C, 1'b1, CPB, 1'b1);
    wait_cycles(CPB);
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL glitch_next: got %02h, expected 3c", data); end
    check_queue_empty("glitch");
  endtask

  task automatic test_frame_err;
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0, CPB, 1'b0);
    wait_cycles(3000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %b, expected 1", busy); end
    rx = 1'b1;
    wait_cycles(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b, expected 0", busy); end
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d pulses, expected 1", ferr_cnt - f0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL ferr_done: got %0d pulses, expected 0", done_cnt - d0); end
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL ferr_data_hold: got %02h, expected 3c", data); end
    send_frame(8'h3C, 1'b1, CPB, 1'b1);
    wait_cycles(CPB);
    checks++; if (data !== 8'h3C || done_cnt - d0 != 1) begin
      errors++; $display("FAIL ferr_next: data=%02h done=%0d, expected 3c 1", data, done_cnt - d0);
    end
    check_queue_empty("ferr");
  endtask

  task automatic test_reset_mid;
    int d0, f0;
    logic [7:0] b;
    d0 = done_cnt; f0 = ferr_cnt;
    b = 8'h96;
    @(posedge clk_50M); #1;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = b[4];
    wait_cycles(CPB / 2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b, expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (data !== 8'h00 || busy !== 1'b0 || rx_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: data=%02h busy=%b done=%b ferr=%b, expected 00 0 0 0",
                         data, busy, rx_done, frame_err);
    end
    rx = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(5);
    send_frame(8'hC3, 1'b1, CPB, 1'b1);
    wait_cycles(CPB);
    checks++; if (data !== 8'hC3) begin errors++; $display("FAIL rstmid_next: got %02h, expected c3", data); end
    checks++; if (done_cnt - d0 != 1 || ferr_cnt != f0) begin
      errors++; $display("FAIL rstmid_strobes: done=%0d ferr=%0d, expected 1 0", done_cnt - d0, ferr_cnt - f0);
    end
    check_queue_empty("rstmid");
  endtask

  task automatic test_back_to_back;
    int d0, f0;
    logic [7:0] b;
    d0 = done_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 128));
      send_frame(b, 1'b1, CPB, 1'b1);
    end
    wait_cycles(CPB);
    checks++; if (done_cnt - d0 != 20) begin errors++; $display("FAIL stream_done_count: got %0d, expected 20", done_cnt - d0); end
    checks++; if (ferr_cnt != f0) begin errors++; $display("FAIL stream_ferr: got %0d pulses, expected 0", ferr_cnt - f0); end
    check_queue_empty("stream");
  endtask

  task automatic test_baud_tolerance;
    int d0;
    d0 = done_cnt;
    send_frame(8'h6B, 1'b1, int'(CPB) * 98 / 100 + 1, 1'b1);
    send_frame(8'hD4, 1'b1, int'(CPB) * 102 / 100 - 1, 1'b1);
    wait_cycles(CPB);
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL baud_done_count: got %0d, expected 2", done_cnt - d0); end
    checks++; if (data !== 8'hD4) begin errors++; $display("FAIL baud_data: got %02h, expected d4", data); end
    check_queue_empty("baud");
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_boundary;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_back_to_back;
    test_baud_tolerance;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with uart_tx. Consumes the 8N1 line that uart_tx drives: 1 start bit, 8 data bits LSB first, 1 stop bit, line idle high.
- Synchronises the asynchronous rx pin, detects and qualifies start bits, samples each bit at mid-bit, and presents the assembled byte with a one-cycle done strobe.
- Runs on the 50 MHz system clock at 115200 baud, the same bit timing as the transmitter.

Parameters:
CLK_FREQ  50000000  system clock frequency in Hz
BAUD      115200    line bit rate
CLKS_PER_BIT  CLK_FREQ/BAUD (integer division = 434)  clock cycles per bit period

Ports:
clk_50M    input   1  system clock; all logic on rising edge
rst        input   1  asynchronous, active-high reset
rx         input   1  serial line from transmitter; asynchronous; idle high
data       output  8  last correctly received byte
rx_done    output  1  one-cycle pulse; data valid and updated this cycle
frame_err  output  1  one-cycle pulse; stop bit sampled low
busy       output  1  high from qualified start detection until the frame ends

Behaviour:
- Interface: one clock, clk_50M. rst is asynchronous and active-high.
- Reset values:
  - Sync flops = 1; state = IDLE.
  - data = 8'h00; rx_done = 0; frame_err = 0; busy = 0.
  - Bit counter and bit index = 0.
- Reset mid-frame aborts immediately; no strobe is generated for the partial frame.
- Input sync: rx passes through two flops (rx_s). The FSM sees only rx_s, so 2 cycles of latency are added.
- Cycle counter: width $clog2(CLKS_PER_BIT). Bit index: 3 bits.
- IDLE:
  - busy = 0.
  - When rx_s == 0: counter = 0, go to START.
- START:
  - Counter increments.
  - At count CLKS_PER_BIT/2-1 (216), rx_s is re-sampled:
    - If 0: valid start. Counter = 0, bit index = 0, busy = 1, go to DATA.
    - If 1: glitch. Return to IDLE with no outputs.
- DATA:
  - Counter increments.
  - At count CLKS_PER_BIT-1: shift_reg[bit_idx] <= rx_s, counter = 0.
  - If bit_idx == 7, go to STOP; otherwise bit_idx increments.
- STOP:
  - At count CLKS_PER_BIT-1, rx_s is sampled.
  - If 1: data <= shift_reg, rx_done = 1 for exactly one cycle, go to IDLE.
  - If 0: data is unchanged, frame_err = 1 for one cycle, go to BREAK.
- BREAK:
  - Waits until rx_s == 1, then goes to IDLE.
  - busy stays high in BREAK.
  - A line held low never produces repeated frames or strobes.
- Latency: rx_done asserts a nominal 2 + 217 + 9*434 = 4125 cycles after the rx falling edge. The bench accepts ±2 cycles.
- data holds its value until the next successful frame. It is never altered by glitches, framing errors or partial frames.
- rx_done and frame_err are mutually exclusive and never high on consecutive cycles.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit. A start edge arriving immediately after the stop bit is therefore caught with no lost frames.
- Baud tolerance: sampling is at mid-bit with no drift correction. Frames are received correctly for transmitter bit periods within ±2% of CLKS_PER_BIT.

Test Plan:
- Loopback with uart_tx, tx_en pulsed with data 8'hA5:
  - rx_done pulses exactly once, about 4125 cycles after the start edge.
  - data = 8'hA5; frame_err stays 0.
- Boundary bytes 8'h00 and then 8'hFF via uart_tx:
  - data = 8'h00, then 8'hFF.
  - One rx_done per byte; no frame_err.
- Glitch: rx driven low for 100 cycles, then high:
  - busy never asserts; no rx_done or frame_err; FSM is back in IDLE.
  - A following valid frame of 8'h3C is received correctly.
- Framing error: hand-driven frame of 8'h5A with the stop bit held low, line kept low for 3000 more cycles, then released:
  - frame_err pulses exactly once; data keeps its prior value; no rx_done.
  - The next frame 8'h3C yields data = 8'h3C.
- Reset mid-frame: rst asserted during data bit 4 of a frame:
  - All outputs return to reset values asynchronously; no strobe.
  - The next full frame 8'hC3 is received correctly.
- Stream: 20 random bytes in the range 0..128 sent back-to-back through uart_tx, each sent after tx_done:
  - 20 rx_done pulses; each data matches the transmitted byte in order; frame_err is never asserted.
